// File: rtl/twp_master_if.sv
// twp_master_if: host request/response bundle between a register host and twp_master.
interface twp_master_if;
  logic        twm_req;
  logic        twm_cmd;
  logic [7:0]  twm_addr;
  logic [15:0] twm_wdata;
  logic        twm_busy;
  logic        twm_done;
  logic [15:0] twm_rdata;
  logic        twm_err;
  modport master (output twm_req, twm_cmd, twm_addr, twm_wdata,
                  input  twm_busy, twm_done, twm_rdata, twm_err);
  modport slave  (input  twm_req, twm_cmd, twm_addr, twm_wdata,
                  output twm_busy, twm_done, twm_rdata, twm_err);
endinterface

// File: rtl/twp_master.sv
// twp_master: serialises host register requests into TWP frames on SDA; optional TWM_PREAMBLE_CHK_EN.
module twp_master (
  input  logic clk,
  input  logic reset,
  output logic SCL,
  inout  wire  SDA,
  twp_master_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, CMD, ADDR, WDATA, TURN, RDATA, TAIL} state_t;
  state_t      state, state_n;
  logic [3:0]  cnt;
  logic        cmd_q;
  logic [7:0]  addr_q;
  logic [15:0] wdata_q, shreg, rdata;
  logic        done, sda_o, sda_oe, accept, fin;
  assign accept = state == IDLE && bus.twm_req;
  assign fin = (state == WDATA && cnt == 4'd15) || (state == TAIL && cnt == 4'd1);
  assign SDA = sda_oe ? sda_o : 1'bz;
  assign SCL = state != IDLE;
  assign bus.twm_busy = state != IDLE;
  assign bus.twm_done = done;
  assign bus.twm_rdata = rdata;
  always_comb begin
    state_n = state;
    sda_oe = 1'b1;
    sda_o = 1'b1;
    case (state)
      IDLE:  state_n = bus.twm_req ? START : IDLE;
      START: begin sda_o = 1'b0; state_n = CMD; end
      CMD:   begin sda_o = cmd_q; state_n = ADDR; end
      ADDR:  begin sda_o = addr_q[cnt[2:0]]; state_n = cnt == 4'd7 ? (cmd_q ? WDATA : TURN) : ADDR; end
      WDATA: begin sda_o = wdata_q[cnt]; state_n = cnt == 4'd15 ? IDLE : WDATA; end
      TURN:  begin sda_oe = 1'b0; state_n = cnt == 4'd3 ? RDATA : TURN; end
      RDATA: begin sda_oe = 1'b0; state_n = cnt == 4'd15 ? TAIL : RDATA; end
      TAIL:  begin sda_oe = 1'b0; state_n = cnt == 4'd1 ? IDLE : TAIL; end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      done <= 1'b0;
      rdata <= 16'h0000;
      shreg <= 16'h0000;
      cmd_q <= 1'b0;
      addr_q <= 8'h00;
      wdata_q <= 16'h0000;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? 4'd0 : cnt + 4'd1;
      done <= fin;
      if (state == TAIL && cnt == 4'd1) rdata <= shreg;
      if (state == RDATA) shreg[cnt] <= SDA;
      if (accept) begin
        cmd_q <= bus.twm_cmd;
        addr_q <= bus.twm_addr;
        wdata_q <= bus.twm_wdata;
      end
    end
  end
`ifdef TWM_PREAMBLE_CHK_EN
  logic err, bad;
  // the slave's turnaround preamble is 1,0 and its tail marker is 1
  assign bad = (state == TURN && ((cnt == 4'd2 && !SDA) || (cnt == 4'd3 && SDA)))
            || (state == TAIL && cnt == 4'd0 && !SDA);
  always_ff @(posedge clk) err <= reset || accept ? 1'b0 : (bad ? 1'b1 : err);
  assign bus.twm_err = err;
`else
  assign bus.twm_err = 1'b0;
`endif
endmodule

// File: tb/tb_twp_master.sv
// tb_twp_master: randomized frames against a bench slave and a frame-level reference model.
module tb_twp_master;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic SCL;
  wire  SDA;
  logic slv_oe = 1'b0;
  logic slv_bit = 1'b0;
  assign SDA = slv_oe ? slv_bit : 1'bz;
  always #5 clk = ~clk;
  twp_master_if bus();
  twp_master dut (.clk(clk), .reset(reset), .SCL(SCL), .SDA(SDA), .bus(bus.slave));
`ifdef TWM_PREAMBLE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic [15:0] mem [256];
  logic [15:0] rdata_m;
  logic        err_m;
  int n_pass = 0;
  int n_chk = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic idle(input int c);
    bus.twm_req = 1'b0;
    repeat (c) @(negedge clk);
    chk("done_pulse", {31'd0, bus.twm_done}, 0);
    chk("idle_busy", {31'd0, bus.twm_busy}, 0);
    chk("idle_sda", {31'd0, SDA}, 1);
    chk("err_sticky", {31'd0, bus.twm_err}, {31'd0, err_m});
  endtask
  task automatic frame(input bit cmd, input logic [7:0] a, input logic [15:0] d,
                       input bit hold, input bit bad, input int abort_at);
    int n;
    logic [31:0] exp_bits, exp_oe, obs_bits, obs_oe;
    logic [15:0] w;
    logic any_done;
    n = cmd ? 26 : 32;
    exp_bits = {cmd ? {6'd0, d} : 22'd0, a, cmd, 1'b0};
    exp_oe = cmd ? 32'h03FF_FFFF : 32'h0000_03FF;
    obs_bits = 0;
    obs_oe = 0;
    any_done = 1'b0;
    w = mem[a];
    bus.twm_req = 1'b1;
    bus.twm_cmd = cmd;
    bus.twm_addr = a;
    bus.twm_wdata = d;
    @(negedge clk);
    err_m = 1'b0;
    chk("busy_start", {31'd0, bus.twm_busy}, 1);
    chk("scl_start", {31'd0, SCL}, 1);
    chk("err_clr", {31'd0, bus.twm_err}, 0);
    for (int k = 0; k < n; k++) begin
      if (k == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        chk("rst_sda", {31'd0, SDA}, 1);
        chk("rst_oe", {31'd0, dut.sda_oe}, 1);
        chk("rst_busy", {31'd0, bus.twm_busy}, 0);
        chk("rst_scl", {31'd0, SCL}, 0);
        chk("rst_rdata", {16'd0, bus.twm_rdata}, 0);
        chk("rst_done", {31'd0, bus.twm_done}, 0);
        reset = 1'b0;
        bus.twm_req = 1'b0;
        slv_oe = 1'b0;
        rdata_m = 16'h0000;
        err_m = 1'b0;
        return;
      end
      obs_oe[k] = dut.sda_oe;
      obs_bits[k] = SDA;
      any_done |= bus.twm_done;
      slv_oe = !cmd && k >= 12 && k <= 30;
      slv_bit = k == 12 ? !bad : k == 13 ? 1'b0 : k == 30 ? 1'b1 : w[(k - 14) & 15];
      bus.twm_req = hold ? 1'b1 : (k < n - 1 ? 1'($urandom_range(0, 1)) : 1'b0);
      if (!hold) begin
        bus.twm_cmd = 1'($urandom);
        bus.twm_addr = 8'($urandom);
        bus.twm_wdata = 16'($urandom);
      end
      @(negedge clk);
    end
    slv_oe = 1'b0;
    if (cmd) mem[a] = d;
    else begin
      rdata_m = w;
      err_m = CHK && bad;
    end
    chk(cmd ? "wr_oe" : "rd_oe", obs_oe, exp_oe);
    chk(cmd ? "wr_bits" : "rd_bits", obs_bits & exp_oe, exp_bits & exp_oe);
    chk("early_done", {31'd0, any_done}, 0);
    chk("done", {31'd0, bus.twm_done}, 1);
    chk("done_busy", {31'd0, bus.twm_busy}, 0);
    chk("rdata", {16'd0, bus.twm_rdata}, {16'd0, rdata_m});
    chk("err", {31'd0, bus.twm_err}, {31'd0, err_m});
  endtask
  initial begin
    bus.twm_req = 1'b0;
    bus.twm_cmd = 1'b0;
    bus.twm_addr = 8'h00;
    bus.twm_wdata = 16'h0000;
    rdata_m = 16'h0000;
    err_m = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    repeat (3) @(negedge clk);
    chk("reset_sda", {31'd0, SDA}, 1);
    chk("reset_scl", {31'd0, SCL}, 0);
    chk("reset_busy", {31'd0, bus.twm_busy}, 0);
    chk("reset_done", {31'd0, bus.twm_done}, 0);
    chk("reset_rdata", {16'd0, bus.twm_rdata}, 0);
    chk("reset_err", {31'd0, bus.twm_err}, 0);
    reset = 1'b0;
    idle(2);
    frame(1'b1, 8'hA5, 16'h1234, 1'b0, 1'b0, -1);
    idle(1);
    frame(1'b0, 8'hA5, 16'h0000, 1'b0, 1'b0, -1);
    idle(2);
    mem[8'h3C] = 16'hBEEF;
    frame(1'b0, 8'h3C, 16'h0000, 1'b0, 1'b0, -1);
    idle(1);
    frame(1'b1, 8'h11, 16'hCAFE, 1'b1, 1'b0, -1);
    frame(1'b0, 8'h11, 16'h0000, 1'b0, 1'b0, -1);
    idle(1);
    frame(1'b0, 8'h42, 16'h0000, 1'b0, 1'b1, -1);
    idle(5);
    frame(1'b1, 8'h43, 16'h5A5A, 1'b0, 1'b0, -1);
    idle(1);
    for (int i = 0; i < 24; i++) begin
      automatic bit hold = i < 23 && $urandom_range(0, 2) == 0;
      frame(1'($urandom), 8'($urandom_range(0, 15)), 16'($urandom), hold,
            $urandom_range(0, 5) == 0, -1);
      if (!hold) idle($urandom_range(1, 3));
    end
    frame(1'b1, 8'h77, 16'h8001, 1'b0, 1'b0, 15);
    idle(2);
    frame(1'b0, 8'hA5, 16'h0000, 1'b0, 1'b0, -1);
    idle(1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
